// File: rtl/div.sv
// Sequential unsigned restoring divider: DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, with the same start/busy handshake as mult.
module div #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] a_bi,
  input  logic [VW-1:0] b_bi,
  input  logic          start_i,
  output logic          busy_o,
  output logic [DW-1:0] q_bo,
  output logic [VW-1:0] r_bo,
  output logic          dz_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   rem_q;
  logic [DW-1:0] quo_q;
  logic          busy_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] r_q;
  logic          dz_q;

  logic [VW:0]   rem_sh_d;
  logic          ge_d;
  logic [VW:0]   rem_d;
  logic [DW-1:0] quo_d;
  logic [DW-1:0] dvd_d;
  logic          last_d;
  logic          dz_d;

  // One restoring step: shift in the dividend MSB, trial-subtract the divisor.
  always_comb begin
    rem_sh_d = {rem_q[VW-1:0], dvd_q[DW-1]};
    ge_d     = (rem_sh_d >= {1'b0, dvs_q});
    rem_d    = ge_d ? (rem_sh_d - {1'b0, dvs_q}) : rem_sh_d;
    quo_d    = {quo_q[DW-2:0], ge_d};
    dvd_d    = {dvd_q[DW-2:0], 1'b0};
    last_d   = (cnt_q == CW'(DW - 1));
    dz_d     = (dvs_q == {VW{1'b0}});
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      dvd_q   <= {DW{1'b0}};
      dvs_q   <= {VW{1'b0}};
      rem_q   <= {(VW+1){1'b0}};
      quo_q   <= {DW{1'b0}};
      busy_q  <= 1'b0;
      q_q     <= {DW{1'b0}};
      r_q     <= {VW{1'b0}};
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dvd_q   <= a_bi;
            dvs_q   <= b_bi;
            rem_q   <= {(VW+1){1'b0}};
            quo_q   <= {DW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= WORK;
          end else begin
            state_q <= IDLE;
          end
        end
        WORK: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_d) begin
            // With a zero divisor every step subtracts nothing, so the
            // remainder has shifted in exactly the low VW dividend bits.
            q_q     <= dz_d ? {DW{1'b1}} : quo_d;
            r_q     <= rem_d[VW-1:0];
            dz_q    <= dz_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= WORK;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign q_bo   = q_q;
  assign r_bo   = r_q;
  assign dz_o   = dz_q;

endmodule

// File: doc/div.md
# div

Sequential unsigned divider: the inverse of the team's shift-add multiplier (`mult`) in the functional-circuitry datapath. It computes a DW-bit dividend divided by a VW-bit divisor using restoring division, one quotient bit per clock. It shares `mult`'s start/busy handshake, so a controller can sequence multiply and divide operations identically. Typical use is recovering an operand from a product, e.g. y / a after y = a·b.

## Interface
- DW, default 16: dividend and quotient width.
- VW, default 8: divisor and remainder width (VW ≤ DW).
- clk_i  input  1: clock; all state changes on the rising edge.
- rst_i  input  1: reset, asynchronous, active-high.
- a_bi  input  DW: dividend, unsigned.
- b_bi  input  VW: divisor, unsigned.
- start_i  input  1: start request; sampled on a rising edge while idle.
- busy_o  output  1: high while a division is in progress.
- q_bo  output  DW: quotient; holds the last result.
- r_bo  output  VW: remainder; holds the last result.
- dz_o  output  1: divide-by-zero flag for the last result.

## Operation
- States: IDLE and WORK.
- Counter: ceil(log2(DW+1)) bits.
- Internal registers: dividend shift register (DW bits), divisor (VW bits), partial remainder (VW+1 bits), quotient (DW bits).
- IDLE, start_i=1 at an edge:
  - capture a_bi and b_bi;
  - clear partial remainder and counter;
  - go to WORK.
- IDLE, start_i=0: hold everything.
- WORK, each edge:
  - form rem' = {rem[VW-1:0], dividend MSB};
  - shift the dividend left by 1;
  - if rem' ≥ divisor: rem = rem' − divisor and shift 1 into the quotient LSB;
  - otherwise: rem = rem' and shift 0 into the quotient LSB;
  - increment the counter.
- After the DW-th WORK edge:
  - load q_bo and r_bo from the internal registers;
  - set dz_o = (captured divisor == 0);
  - go to IDLE.
- Divide by zero:
  - the block still runs the full DW cycles;
  - result is forced to q_bo = all ones, r_bo = a_bi[VW-1:0] (captured value), dz_o = 1.
- Outputs q_bo, r_bo and dz_o change only at completion. They hold their value in IDLE and during the next WORK phase.
- Operands are used only at the capture edge. Changes to a_bi/b_bi while busy have no effect.
- start_i while busy_o=1 is ignored. It is not queued.
- start_i held high across completion starts a new division on the first IDLE edge. This matches `mult` behaviour.
- Arithmetic: the partial remainder is VW+1 bits, so the compare/subtract never overflows. The final remainder fits in VW bits because it is less than the divisor.

## Timing
- Reset values (asynchronous, take effect immediately): state IDLE, busy_o=0, q_bo=0, r_bo=0, dz_o=0, all internal registers 0.
- Edge numbering:
  - start sampled at edge 0; busy_o=1 after edge 0;
  - iterations run on edges 1..DW;
  - after edge DW: busy_o=0 and results valid.
- busy_o is high for exactly DW clock cycles per operation.
- Fixed latency: DW+1 edges from sampled start to valid result, independent of operand values.
- Back-to-back: the next start can be sampled at edge DW+1, giving throughput of one division per DW+1 cycles.
- Reset asserted mid-operation:
  - aborts immediately and clears all outputs to reset values;
  - after deassertion the block is in IDLE and needs a new start.
- busy_o, q_bo, r_bo and dz_o are registered outputs; no combinational path from any input.

## Test plan
- Reset with start_i=0, then 10 idle cycles -> busy_o=0, q_bo=0, r_bo=0, dz_o=0 throughout.
- Directed divisions, DW=16/VW=8:
  - a=64, b=8 -> q=8, r=0;
  - a=1000, b=7 -> q=142, r=6;
  - a=65535, b=255 -> q=257, r=0;
  - a=3, b=10 -> q=0, r=3.
  - For each: busy_o high for exactly 16 cycles, and results appear on the edge busy_o falls.
- a=5, b=0 -> q=16'hFFFF, r=5, dz_o=1 after 16 busy cycles. A following a=9, b=3 -> q=3, r=0, dz_o=0.
- Start a=1000, b=7, then pulse start_i with a=50, b=5 and change the operands at cycle 5 of busy:
  - result is still q=142, r=6;
  - busy_o is not extended;
  - q_bo/r_bo keep their previous values until completion.
- Assert rst_i at WORK cycle 8 of a=1000, b=7:
  - busy_o and outputs go to 0 without waiting for a clock edge;
  - after release, a new start with a=64, b=8 gives q=8, r=0.
- Random sweep of 1000 operand pairs with start_i held high (back-to-back) -> each result matches a/b and a%b, with one result every 17 cycles.
